free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter RENAME_WIDTH, default 4, rename slots per cycle.
REQ-002 SHALL have parameter COMMIT_WIDTH, default 4, retire slots per cycle.
REQ-003 SHALL have parameter ARF_INT_SIZE, default 32, architectural integer registers.
REQ-004 SHALL have parameter PRF_INT_SIZE, default 64, physical integer registers; PRF_IDX = log2(PRF_INT_SIZE).
REQ-005 SHALL have parameter RAT_CP_SIZE, default 4, checkpoint slots; CP_IDX = log2(RAT_CP_SIZE).
REQ-006 SHALL define FL_DEPTH = PRF_INT_SIZE - ARF_INT_SIZE and CNT_W = log2(FL_DEPTH)+1.
REQ-007 clock  input  1  sole clock, all state on rising edge.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 stall  input  1  downstream stall; blocks allocation only.
REQ-010 alloc_req  input  RENAME_WIDTH  per-slot request for one new physical destination.
REQ-011 alloc_prf  output  RENAME_WIDTH x PRF_IDX  granted physical index per slot.
REQ-012 allocatable  output  1  enough free entries for every set alloc_req bit.
REQ-013 free_req  input  COMMIT_WIDTH  per-slot release of a retired previous mapping.
REQ-014 free_prf  input  COMMIT_WIDTH x PRF_IDX  physical index released per slot.
REQ-015 check  input  1  take a head checkpoint this cycle.
REQ-016 check_idx  input  CP_IDX  checkpoint slot to write.
REQ-017 check_flag  input  RENAME_WIDTH  one-hot branch slot the checkpoint follows.
REQ-018 recover  input  1  branch mispredict recovery.
REQ-019 recover_idx  input  CP_IDX  checkpoint slot to restore.
REQ-020 free_count  output  CNT_W  entries currently free.

Function
REQ-021 SHALL hold FL_DEPTH PRF indices in a circular buffer with head and tail pointers of CNT_W bits (extra wrap bit); free_count = tail - head modulo 2^CNT_W, driven from registers only.
REQ-022 alloc_prf[i] SHALL equal entry[(head + number of set alloc_req bits in slots < i) mod FL_DEPTH] when alloc_req[i]=1, else 0; combinational.
REQ-023 allocatable SHALL equal (free_count >= popcount(alloc_req)) & !recover; stall does not affect it.
REQ-024 fire = !stall & allocatable & !recover; on fire head SHALL advance by popcount(alloc_req); otherwise head SHALL hold, except on recover.
REQ-025 each set free_req[j] SHALL write free_prf[j] at tail + (set free_req bits in slots < j) and tail SHALL advance by popcount(free_req); accepted every cycle regardless of stall, allocatable, recover.
REQ-026 entries freed in cycle N SHALL NOT be allocatable before cycle N+1.
REQ-027 on fire & check, cp[check_idx] SHALL be written with head + popcount(alloc_req bits in slots <= the check_flag slot); check without fire SHALL write nothing.
REQ-028 on recover, head SHALL load cp[recover_idx]; alloc_req and check are ignored that cycle; frees of the same cycle SHALL still apply to tail.
REQ-029 push causing free_count > FL_DEPTH and check_flag not one-hot while check=1 are protocol violations; SHALL be flagged by simulation assertions; RTL behaviour undefined.
REQ-030 pointer arithmetic SHALL wrap modulo 2^CNT_W; buffer index = pointer mod FL_DEPTH (FL_DEPTH a power of two).

Reset
REQ-031 on clock edge with reset=0: entry[i] = ARF_INT_SIZE + i, head = 0, tail = FL_DEPTH, all cp = 0; reset overrides stall, recover, free_req, check.
REQ-032 after reset: free_count = FL_DEPTH (32), allocatable = 1 for any alloc_req, alloc_prf outputs per REQ-022.

Verification
REQ-033 reset, alloc_req=1111, stall=0 -> alloc_prf = 32,33,34,35; next cycle free_count=28, alloc_req=1111 yields 36..39.
REQ-034 after reset alloc_req=0101 -> alloc_prf[0]=32, alloc_prf[2]=33, slots 1,3 = 0; next free_count=30.
REQ-035 drain to free_count=2, alloc_req=0111 -> allocatable=0, head unchanged; then alloc_req=0001, stall=1 -> allocatable=1, head unchanged.
REQ-036 allocate all 32, free_req=0011 free_prf={7,5} -> same cycle allocatable=0 for alloc_req=0001; next cycle free_count=2, alloc_req=0011 returns 5 then 7 (slot0, slot1).
REQ-037 from reset: alloc_req=1111, check=1, check_flag=0010, check_idx=1 -> cp[1]=2; two more alloc of 1111; recover=1, recover_idx=1, free_req=0001 -> next free_count=31, alloc_req=0001 returns 34.
REQ-038 reset=0 asserted mid-stream with recover=1 and free_req=1111 -> next cycle state equals REQ-031, free_count=32.

Source files
------------

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free PRF indices with
// multi-slot allocate at the head, multi-slot release at the tail, and
// head checkpoints for branch-mispredict recovery.
module free_list #(
  parameter int unsigned RENAME_WIDTH = 4,
  parameter int unsigned COMMIT_WIDTH = 4,
  parameter int unsigned ARF_INT_SIZE = 32,
  parameter int unsigned PRF_INT_SIZE = 64,
  parameter int unsigned RAT_CP_SIZE  = 4,
  localparam int unsigned PRF_IDX  = $clog2(PRF_INT_SIZE),
  localparam int unsigned CP_IDX   = $clog2(RAT_CP_SIZE),
  localparam int unsigned FL_DEPTH = PRF_INT_SIZE - ARF_INT_SIZE,
  localparam int unsigned CNT_W    = $clog2(FL_DEPTH) + 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 stall,
  input  logic [RENAME_WIDTH-1:0]              alloc_req,
  output logic [RENAME_WIDTH-1:0][PRF_IDX-1:0] alloc_prf,
  output logic                                 allocatable,
  input  logic [COMMIT_WIDTH-1:0]              free_req,
  input  logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0] free_prf,
  input  logic                                 check,
  input  logic [CP_IDX-1:0]                    check_idx,
  input  logic [RENAME_WIDTH-1:0]              check_flag,
  input  logic                                 recover,
  input  logic [CP_IDX-1:0]                    recover_idx,
  output logic [CNT_W-1:0]                     free_count
);

  localparam int unsigned FL_IDX = $clog2(FL_DEPTH);

  logic [PRF_IDX-1:0] entry_q [FL_DEPTH];
  logic [CNT_W-1:0]   head_q;
  logic [CNT_W-1:0]   tail_q;
  logic [CNT_W-1:0]   cp_q    [RAT_CP_SIZE];

  logic [CNT_W-1:0]   alloc_cnt;
  logic [CNT_W-1:0]   cp_ofs;
  logic [CNT_W-1:0]   free_cnt;
  logic [FL_IDX-1:0]  free_addr [COMMIT_WIDTH];
  logic               fire;

  // Occupancy straight from the pointer registers; wrap bit makes full vs empty distinct.
  assign free_count = tail_q - head_q;

  // Compact the requesting slots onto consecutive head entries; note checkpoint offset.
  always_comb begin
    alloc_cnt = '0;
    cp_ofs    = '0;
    alloc_prf = '0;
    for (int i = 0; i < int'(RENAME_WIDTH); i++) begin
      if (alloc_req[i]) begin
        alloc_prf[i] = entry_q[FL_IDX'(head_q + alloc_cnt)];
        alloc_cnt    = alloc_cnt + CNT_W'(1);
      end
      if (check_flag[i]) cp_ofs = alloc_cnt;
    end
  end

  // Grant only when every request fits in entries already present; recovery blocks it.
  always_comb begin
    allocatable = (free_count >= alloc_cnt) && !recover;
    fire        = !stall && allocatable;
  end

  // Compact released slots onto consecutive tail positions.
  always_comb begin
    free_cnt = '0;
    for (int j = 0; j < int'(COMMIT_WIDTH); j++) begin
      free_addr[j] = FL_IDX'(tail_q + free_cnt);
      if (free_req[j]) free_cnt = free_cnt + CNT_W'(1);
    end
  end

  // Buffer, pointer and checkpoint state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(FL_DEPTH); i++) entry_q[i] <= PRF_IDX'(ARF_INT_SIZE + i);
      head_q <= '0;
      tail_q <= CNT_W'(FL_DEPTH);
      for (int k = 0; k < int'(RAT_CP_SIZE); k++) cp_q[k] <= '0;
    end else begin
      for (int j = 0; j < int'(COMMIT_WIDTH); j++) begin
        if (free_req[j]) entry_q[free_addr[j]] <= free_prf[j];
      end
      tail_q <= tail_q + free_cnt;
      if (recover) begin
        head_q <= cp_q[recover_idx];
      end else if (fire) begin
        head_q <= head_q + alloc_cnt;
      end
      if (fire && check) cp_q[check_idx] <= head_q + cp_ofs;
    end
  end

`ifndef SYNTHESIS
  // Protocol checks: no over-release, and checkpoints name exactly one branch slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (recover || (int'(free_count) + int'(free_cnt) -
                          (fire ? int'(alloc_cnt) : 0) <= int'(FL_DEPTH)))
        else $error("free_list: release overflows the free list");
      assert (!check || $onehot(check_flag))
        else $error("free_list: check_flag is not one-hot");
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed checks of free_list against a history-sequence model:
// every index ever released is appended to a list, head/tail are absolute positions.
module tb_free_list;

  localparam int unsigned RW    = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned PIDX  = 6;
  localparam int unsigned CPI   = 2;
  localparam int unsigned CNTW  = 6;
  localparam int          DEPTH = 32;

  logic                     clock;
  logic                     reset;
  logic                     stall;
  logic [RW-1:0]            alloc_req;
  logic [RW-1:0][PIDX-1:0]  alloc_prf;
  logic                     allocatable;
  logic [CW-1:0]            free_req;
  logic [CW-1:0][PIDX-1:0]  free_prf;
  logic                     check;
  logic [CPI-1:0]           check_idx;
  logic [RW-1:0]            check_flag;
  logic                     recover;
  logic [CPI-1:0]           recover_idx;
  logic [CNTW-1:0]          free_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: hist holds every index ever placed in the list, in order.
  int hist[$];
  int mhead, mtail;
  int mcp[4];
  bit cp_valid[4];

  free_list dut (
    .clock(clock), .reset(reset), .stall(stall),
    .alloc_req(alloc_req), .alloc_prf(alloc_prf), .allocatable(allocatable),
    .free_req(free_req), .free_prf(free_prf),
    .check(check), .check_idx(check_idx), .check_flag(check_flag),
    .recover(recover), .recover_idx(recover_idx), .free_count(free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    stall = 0; alloc_req = '0; free_req = '0; free_prf = '0;
    check = 0; check_idx = '0; check_flag = 4'b0001;
    recover = 0; recover_idx = '0;
  endtask

  // Apply the current inputs to the model, then clock the DUT.
  task automatic tick();
    int na, k, off;
    bit fire;
    if (!reset) begin
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back(32 + i);
      mhead = 0; mtail = DEPTH;
      for (int c = 0; c < 4; c++) begin mcp[c] = 0; cp_valid[c] = 0; end
    end else begin
      na   = $countones(alloc_req);
      fire = !stall && !recover && (mtail - mhead >= na);
      for (int j = 0; j < int'(CW); j++)
        if (free_req[j]) begin hist.push_back(int'(free_prf[j])); mtail++; end
      if (recover) mhead = mcp[recover_idx];
      else if (fire) begin
        if (check) begin
          k = 0;
          for (int i = 0; i < int'(RW); i++) if (check_flag[i]) k = i;
          off = 0;
          for (int i = 0; i <= k; i++) if (alloc_req[i]) off++;
          mcp[check_idx] = mhead + off;
          cp_valid[check_idx] = 1;
        end
        mhead += na;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 0; idle(); tick(); reset = 1; idle();
  endtask

  task automatic test_reset();
    reset = 0; idle();
    recover = 1; free_req = 4'hF; check = 1; alloc_req = 4'hF; free_prf = {6'd1, 6'd2, 6'd3, 6'd4};
    tick();
    reset = 1; idle(); alloc_req = 4'hF; #1;
    n_checks++;
    if (free_count !== 6'd32) begin n_fail++; $display("FAIL reset_count: got %0d want 32", free_count); end
    n_checks++;
    if (allocatable !== 1'b1) begin n_fail++; $display("FAIL reset_allocatable: got %b want 1", allocatable); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (alloc_prf[i] !== PIDX'(32 + i)) begin
        n_fail++; $display("FAIL reset_prf[%0d]: got %0d want %0d", i, alloc_prf[i], 32 + i);
      end
    end
    alloc_req = '0; #1;
    n_checks++;
    if (allocatable !== 1'b1 || alloc_prf !== '0) begin
      n_fail++; $display("FAIL reset_noreq: allocatable %b prf %h want 1 and 0", allocatable, alloc_prf);
    end
  endtask

  task automatic test_alloc_full();
    do_reset(); alloc_req = 4'hF; #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (alloc_prf[i] !== PIDX'(32 + i)) begin n_fail++; $display("FAIL full1_prf[%0d]: got %0d want %0d", i, alloc_prf[i], 32 + i); end
    end
    tick();
    n_checks++;
    if (free_count !== 6'd28) begin n_fail++; $display("FAIL full_count: got %0d want 28", free_count); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (alloc_prf[i] !== PIDX'(36 + i)) begin n_fail++; $display("FAIL full2_prf[%0d]: got %0d want %0d", i, alloc_prf[i], 36 + i); end
    end
    tick(); idle();
  endtask

  task automatic test_sparse();
    do_reset(); alloc_req = 4'b0101; #1;
    n_checks++;
    if (alloc_prf[0] !== 6'd32 || alloc_prf[1] !== 6'd0 || alloc_prf[2] !== 6'd33 || alloc_prf[3] !== 6'd0) begin
      n_fail++; $display("FAIL sparse_prf: got %0d,%0d,%0d,%0d want 32,0,33,0", alloc_prf[0], alloc_prf[1], alloc_prf[2], alloc_prf[3]);
    end
    tick(); idle(); #1;
    n_checks++;
    if (free_count !== 6'd30) begin n_fail++; $display("FAIL sparse_count: got %0d want 30", free_count); end
  endtask

  task automatic test_alloc_block();
    do_reset(); alloc_req = 4'hF;
    repeat (7) tick();
    alloc_req = 4'b0011; tick();
    alloc_req = 4'b0111; #1;
    n_checks++;
    if (allocatable !== 1'b0) begin n_fail++; $display("FAIL block_allocatable: got %b want 0", allocatable); end
    tick();
    n_checks++;
    if (free_count !== 6'd2) begin n_fail++; $display("FAIL block_hold: got %0d want 2", free_count); end
    alloc_req = 4'b0001; stall = 1; #1;
    n_checks++;
    if (allocatable !== 1'b1) begin n_fail++; $display("FAIL stall_allocatable: got %b want 1", allocatable); end
    tick();
    n_checks++;
    if (free_count !== 6'd2 || alloc_prf[0] !== 6'd62) begin
      n_fail++; $display("FAIL stall_hold: count %0d prf %0d want 2 and 62", free_count, alloc_prf[0]);
    end
    stall = 0; tick(); idle(); #1;
    n_checks++;
    if (free_count !== 6'd1) begin n_fail++; $display("FAIL block_after: got %0d want 1", free_count); end
  endtask

  task automatic test_free_same_cycle();
    do_reset(); alloc_req = 4'hF;
    repeat (8) tick();
    alloc_req = 4'b0001; free_req = 4'b0011; free_prf[0] = 6'd5; free_prf[1] = 6'd7; #1;
    n_checks++;
    if (free_count !== 6'd0 || allocatable !== 1'b0) begin
      n_fail++; $display("FAIL free_same: count %0d allocatable %b want 0 and 0", free_count, allocatable);
    end
    tick();
    free_req = '0; alloc_req = 4'b0011; #1;
    n_checks++;
    if (free_count !== 6'd2 || allocatable !== 1'b1 || alloc_prf[0] !== 6'd5 || alloc_prf[1] !== 6'd7) begin
      n_fail++; $display("FAIL free_next: count %0d alw %b prf %0d,%0d want 2,1,5,7",
                         free_count, allocatable, alloc_prf[0], alloc_prf[1]);
    end
    tick(); idle();
  endtask

  task automatic test_checkpoint();
    do_reset();
    alloc_req = 4'hF; check = 1; check_flag = 4'b0010; check_idx = 2'd1;
    tick();
    check = 0;
    repeat (2) tick();
    recover = 1; recover_idx = 2'd1; free_req = 4'b0001; free_prf[0] = 6'd9;
    check = 1; check_flag = 4'b0001; check_idx = 2'd1; #1;
    n_checks++;
    if (allocatable !== 1'b0) begin n_fail++; $display("FAIL recover_allocatable: got %b want 0", allocatable); end
    tick();
    idle(); alloc_req = 4'b0001; #1;
    n_checks++;
    if (free_count !== 6'd31 || alloc_prf[0] !== 6'd34) begin
      n_fail++; $display("FAIL recover1: count %0d prf %0d want 31 and 34", free_count, alloc_prf[0]);
    end
    tick();
    idle(); recover = 1; recover_idx = 2'd1; tick();
    idle(); alloc_req = 4'b0001; #1;
    n_checks++;
    if (free_count !== 6'd31 || alloc_prf[0] !== 6'd34) begin
      n_fail++; $display("FAIL recover2: count %0d prf %0d want 31 and 34", free_count, alloc_prf[0]);
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    alloc_req = 4'hF; check = 1; check_flag = 4'b1000; check_idx = 2'd3;
    tick(); check = 0; tick();
    reset = 0; recover = 1; recover_idx = 2'd3; free_req = 4'hF;
    free_prf = {6'd11, 6'd12, 6'd13, 6'd14}; check = 1; check_flag = 4'b0001;
    tick();
    reset = 1; idle(); alloc_req = 4'hF; #1;
    n_checks++;
    if (free_count !== 6'd32 || allocatable !== 1'b1) begin
      n_fail++; $display("FAIL midreset_count: count %0d alw %b want 32 and 1", free_count, allocatable);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (alloc_prf[i] !== PIDX'(32 + i)) begin n_fail++; $display("FAIL midreset_prf[%0d]: got %0d want %0d", i, alloc_prf[i], 32 + i); end
    end
    tick();
    idle(); recover = 1; recover_idx = 2'd3; tick(); idle(); #1;
    n_checks++;
    if (free_count !== 6'd32) begin n_fail++; $display("FAIL midreset_cp: got %0d want 32", free_count); end
  endtask

  task automatic test_random();
    int floor_v, nv, pick, expv, rank;
    int vidx[$];
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      idle();
      if ($urandom_range(19) == 0) for (int c = 0; c < 4; c++) cp_valid[c] = 0;
      floor_v = mhead;
      vidx.delete();
      for (int c = 0; c < 4; c++) if (cp_valid[c]) begin
        vidx.push_back(c);
        if (mcp[c] < floor_v) floor_v = mcp[c];
      end
      stall     = ($urandom_range(3) == 0);
      alloc_req = RW'($urandom);
      free_req  = CW'($urandom);
      for (int j = 0; j < int'(CW); j++) free_prf[j] = PIDX'($urandom);
      while (mtail + $countones(free_req) - floor_v > DEPTH) free_req = free_req & (free_req - 4'd1);
      nv = vidx.size();
      if (nv > 0 && $urandom_range(9) == 0) begin
        pick = int'($urandom_range(nv - 1));
        recover = 1; recover_idx = CPI'(vidx[pick]);
      end
      check      = ($urandom_range(2) == 0);
      check_idx  = CPI'($urandom);
      check_flag = RW'(1 << $urandom_range(3));
      #1;
      n_checks++;
      if (free_count !== CNTW'(mtail - mhead)) begin
        n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, free_count, mtail - mhead);
      end
      n_checks++;
      if (allocatable !== ((mtail - mhead >= $countones(alloc_req)) && !recover)) begin
        n_fail++; $display("FAIL rnd_allocatable @%0d: got %b req %b count %0d", cyc, allocatable, alloc_req, mtail - mhead);
      end
      rank = 0;
      for (int i = 0; i < int'(RW); i++) begin
        if (!alloc_req[i]) begin
          n_checks++;
          if (alloc_prf[i] !== '0) begin n_fail++; $display("FAIL rnd_idle_prf[%0d] @%0d: got %0d want 0", i, cyc, alloc_prf[i]); end
        end else begin
          if (mhead + rank < mtail) begin
            expv = hist[mhead + rank];
            n_checks++;
            if (alloc_prf[i] !== PIDX'(expv)) begin
              n_fail++; $display("FAIL rnd_prf[%0d] @%0d: got %0d want %0d", i, cyc, alloc_prf[i], expv);
            end
          end
          rank++;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 0;
    test_reset();
    test_alloc_full();
    test_sparse();
    test_alloc_block();
    test_free_same_cycle();
    test_checkpoint();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
